// File: rtl/fpc_pkg.sv
// Shared FPC definitions: lane widths, forbidden-pattern check and the golden encode table.
package fpc_pkg;

    localparam int unsigned FPC_CW_W = 5;
    localparam int unsigned FPC_DW   = 4;

    // Data nibble d maps to FPC_ENC[d]; the 16 codewords free of 010/101, in ascending order.
    localparam logic [FPC_CW_W-1:0] FPC_ENC [16] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00110,
        5'b00111, 5'b01100, 5'b01110, 5'b01111,
        5'b10000, 5'b10001, 5'b10011, 5'b11000,
        5'b11001, 5'b11100, 5'b11110, 5'b11111
    };

    function automatic logic fpc_invalid(input logic [FPC_CW_W-1:0] cw);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (cw[i +: 3] == 3'b010 || cw[i +: 3] == 3'b101) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/fpc_dec_stream_if.sv
// Input codeword stream and output decoded stream of the FPC bus decoder.
interface fpc_dec_stream_if
    import fpc_pkg::*;
#(
    parameter int unsigned LANES = 8
) ();

    logic                         in_valid;
    logic                         in_ready;
    logic [FPC_CW_W*LANES-1:0]    data_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [FPC_DW*LANES-1:0]      data_out;
    logic [LANES-1:0]             err_lane;

    modport master (
        output in_valid, data_in, out_ready,
        input  in_ready, out_valid, data_out, err_lane
    );

    modport slave (
        input  in_valid, data_in, out_ready,
        output in_ready, out_valid, data_out, err_lane
    );

endinterface

// File: rtl/fpc_dec.sv
// Single-lane 5->4 FPC decoder; codes outside the table pass their low nibble through.
module fpc_dec
    import fpc_pkg::*;
(
    input  logic [FPC_CW_W-1:0] cw,
    output logic [FPC_DW-1:0]   data
);

    always_comb begin
        data = FPC_DW'(cw);
        case (cw)
            5'b00000: data = 4'h0;
            5'b00001: data = 4'h1;
            5'b00011: data = 4'h2;
            5'b00110: data = 4'h3;
            5'b00111: data = 4'h4;
            5'b01100: data = 4'h5;
            5'b01110: data = 4'h6;
            5'b01111: data = 4'h7;
            5'b10000: data = 4'h8;
            5'b10001: data = 4'h9;
            5'b10011: data = 4'hA;
            5'b11000: data = 4'hB;
            5'b11001: data = 4'hC;
            5'b11100: data = 4'hD;
            5'b11110: data = 4'hE;
            5'b11111: data = 4'hF;
            default:  data = FPC_DW'(cw);
        endcase
    end

endmodule

// File: rtl/fpc_dec_stream.sv
// Flow-controlled FPC bus decoder: per-lane decode and error flag, 2-entry output FIFO, error stats.
module fpc_dec_stream
    import fpc_pkg::*;
#(
    parameter int unsigned LANES    = 8,
    parameter int unsigned CNT_W    = 16,
    parameter bit          ERR_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    fpc_dec_stream_if.slave   bus,
    input  logic              clr_err,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky
);

    localparam int unsigned DW = FPC_DW * LANES;
    localparam int unsigned EW = DW + LANES;

    logic [DW-1:0]    dec_raw;
    logic [DW-1:0]    dec_data;
    logic [LANES-1:0] dec_err;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        fpc_dec u_dec (
            .cw   (bus.data_in[k*FPC_CW_W +: FPC_CW_W]),
            .data (dec_raw[k*FPC_DW +: FPC_DW])
        );
        assign dec_err[k] = fpc_invalid(bus.data_in[k*FPC_CW_W +: FPC_CW_W]);
        assign dec_data[k*FPC_DW +: FPC_DW] =
            (ERR_ZERO && dec_err[k]) ? '0 : dec_raw[k*FPC_DW +: FPC_DW];
    end

    logic [1:0]       count_q, count_d;
    logic [EW-1:0]    ent0_q, ent0_d;
    logic [EW-1:0]    ent1_q, ent1_d;
    logic             rdy_q, rdy_d;
    logic             vld_q, vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d;
    logic             push, pop, any_acc;

    assign push    = bus.in_valid & rdy_q;
    assign pop     = vld_q & bus.out_ready;
    assign any_acc = push & (|dec_err);

    // ent0 is the head and drives the outputs directly, so it keeps its value once drained.
    always_comb begin
        count_d  = count_q;
        ent0_d   = ent0_q;
        ent1_d   = ent1_q;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;

        if (pop && count_q == 2'd2) begin
            ent0_d = ent1_q;
        end
        if (push) begin
            if (count_q == 2'd0 || (count_q == 2'd1 && pop)) begin
                ent0_d = {dec_err, dec_data};
            end else begin
                ent1_d = {dec_err, dec_data};
            end
        end
        count_d = count_q + 2'(push) - 2'(pop);

        if (clr_err) begin
            cnt_d    = CNT_W'(any_acc);
            sticky_d = any_acc;
        end else if (any_acc) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            sticky_d = 1'b1;
        end

        rdy_d = (count_d != 2'd2);
        vld_d = (count_d != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q  <= 2'd0;
            ent0_q   <= '0;
            ent1_q   <= '0;
            rdy_q    <= 1'b0;
            vld_q    <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            rdy_q    <= rdy_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.data_out  = ent0_q[DW-1:0];
    assign bus.err_lane  = ent0_q[EW-1:DW];
    assign err_cnt       = cnt_q;
    assign err_sticky    = sticky_q;

endmodule
